// File: rtl/serial_seq_detector.sv
// serial_seq_detector: Moore FSM detecting 1011 in a gated serial stream; DETECT_OVERLAP_EN enables overlapping matches
module serial_seq_detector #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] shift_q,
    output logic [2:0]       state,
    output logic             detect,
    output logic [CNT_W-1:0] match_count
);
    localparam logic [2:0] S0    = 3'd0;
    localparam logic [2:0] S1    = 3'd1;
    localparam logic [2:0] S10   = 3'd2;
    localparam logic [2:0] S101  = 3'd3;
    localparam logic [2:0] S1011 = 3'd4;
`ifdef DETECT_OVERLAP_EN
    localparam logic [2:0] AFTER_MATCH_0 = S10;
`else
    localparam logic [2:0] AFTER_MATCH_0 = S0;
`endif
    logic [2:0]       state_q, state_d, nxt;
    logic [WIDTH-1:0] shift_d;
    logic             detect_q, detect_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             illegal, hit;
    always_comb begin
        case (state_q)
            S0:      nxt = din ? S1 : S0;
            S1:      nxt = din ? S1 : S10;
            S10:     nxt = din ? S101 : S0;
            S101:    nxt = din ? S1011 : S10;
            S1011:   nxt = din ? S1 : AFTER_MATCH_0;
            default: nxt = S0;
        endcase
        illegal  = state_q > S1011;
        hit      = din_valid && !illegal && nxt == S1011;
        state_d  = (din_valid || illegal) ? nxt : state_q;
        shift_d  = din_valid ? {shift_q[WIDTH-2:0], din} : shift_q;
        detect_d = hit;
        count_d  = (hit && count_q != '1) ? count_q + 1'b1 : count_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S0;
            shift_q  <= '0;
            detect_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            detect_q <= detect_d;
            count_q  <= count_d;
        end
    end
    assign state       = state_q;
    assign detect      = detect_q;
    assign match_count = count_q;
endmodule

// File: tb/tb_serial_seq_detector.sv
// tb_serial_seq_detector: table-driven vectors plus a saturation sequence on a CNT_W=2 instance
module tb_serial_seq_detector;
`ifdef DETECT_OVERLAP_EN
    localparam bit OV = 1'b1;
`else
    localparam bit OV = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       reset, din, din_valid;
    logic [7:0] shift_q, shift2;
    logic [2:0] state, state2;
    logic       detect, detect2;
    logic [7:0] match_count;
    logic [1:0] count2;
    int         n_checks = 0;
    int         n_pass = 0;
    typedef struct {
        logic       rst, d, v;
        logic [7:0] sh;
        logic [2:0] st;
        logic       det;
        logic [7:0] cnt;
    } vec_t;
    vec_t tv[$];
    always #5 clk = ~clk;
    serial_seq_detector #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .shift_q(shift_q), .state(state), .detect(detect), .match_count(match_count)
    );
    serial_seq_detector #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .shift_q(shift2), .state(state2), .detect(detect2), .match_count(count2)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask
    task automatic step(input logic r, input logic d, input logic v);
        @(negedge clk);
        reset = r;
        din = d;
        din_valid = v;
        @(posedge clk);
        #1;
    endtask
    function automatic vec_t mk(input logic r, d, v, input logic [7:0] sh, input logic [2:0] st,
                                input logic det, input logic [7:0] cnt);
        vec_t t;
        t.rst = r; t.d = d; t.v = v; t.sh = sh; t.st = st; t.det = det; t.cnt = cnt;
        return t;
    endfunction
    initial begin
        reset = 1'b1;
        din = 1'b1;
        din_valid = 1'b1;
        // reset held with din=1, valid=1
        tv.push_back(mk(1, 1, 1, 8'h00, 3'd0, 0, 8'd0));
        tv.push_back(mk(1, 1, 1, 8'h00, 3'd0, 0, 8'd0));
        // basic match, then idle in S1011
        tv.push_back(mk(0, 1, 1, 8'h01, 3'd1, 0, 8'd0));
        tv.push_back(mk(0, 0, 1, 8'h02, 3'd2, 0, 8'd0));
        tv.push_back(mk(0, 1, 1, 8'h05, 3'd3, 0, 8'd0));
        tv.push_back(mk(0, 1, 1, 8'h0B, 3'd4, 1, 8'd1));
        tv.push_back(mk(0, 0, 0, 8'h0B, 3'd4, 0, 8'd1));
        tv.push_back(mk(0, 1, 0, 8'h0B, 3'd4, 0, 8'd1));
        // overlap stream 1011011
        tv.push_back(mk(1, 0, 0, 8'h00, 3'd0, 0, 8'd0));
        tv.push_back(mk(0, 1, 1, 8'h01, 3'd1, 0, 8'd0));
        tv.push_back(mk(0, 0, 1, 8'h02, 3'd2, 0, 8'd0));
        tv.push_back(mk(0, 1, 1, 8'h05, 3'd3, 0, 8'd0));
        tv.push_back(mk(0, 1, 1, 8'h0B, 3'd4, 1, 8'd1));
        tv.push_back(mk(0, 0, 1, 8'h16, OV ? 3'd2 : 3'd0, 0, 8'd1));
        tv.push_back(mk(0, 1, 1, 8'h2D, OV ? 3'd3 : 3'd1, 0, 8'd1));
        tv.push_back(mk(0, 1, 1, 8'h5B, OV ? 3'd4 : 3'd1, OV, OV ? 8'd2 : 8'd1));
        tv.push_back(mk(0, 0, 0, 8'h5B, OV ? 3'd4 : 3'd1, 0, OV ? 8'd2 : 8'd1));
        // 1,0,1,1 separated by 3 invalid cycles with din toggling
        tv.push_back(mk(1, 0, 0, 8'h00, 3'd0, 0, 8'd0));
        tv.push_back(mk(0, 1, 1, 8'h01, 3'd1, 0, 8'd0));
        tv.push_back(mk(0, 0, 0, 8'h01, 3'd1, 0, 8'd0));
        tv.push_back(mk(0, 1, 0, 8'h01, 3'd1, 0, 8'd0));
        tv.push_back(mk(0, 0, 0, 8'h01, 3'd1, 0, 8'd0));
        tv.push_back(mk(0, 0, 1, 8'h02, 3'd2, 0, 8'd0));
        tv.push_back(mk(0, 1, 0, 8'h02, 3'd2, 0, 8'd0));
        tv.push_back(mk(0, 0, 0, 8'h02, 3'd2, 0, 8'd0));
        tv.push_back(mk(0, 1, 0, 8'h02, 3'd2, 0, 8'd0));
        tv.push_back(mk(0, 1, 1, 8'h05, 3'd3, 0, 8'd0));
        tv.push_back(mk(0, 0, 0, 8'h05, 3'd3, 0, 8'd0));
        tv.push_back(mk(0, 1, 0, 8'h05, 3'd3, 0, 8'd0));
        tv.push_back(mk(0, 0, 0, 8'h05, 3'd3, 0, 8'd0));
        tv.push_back(mk(0, 1, 1, 8'h0B, 3'd4, 1, 8'd1));
        tv.push_back(mk(0, 0, 0, 8'h0B, 3'd4, 0, 8'd1));
        // reset on the edge that would complete a match
        tv.push_back(mk(1, 0, 0, 8'h00, 3'd0, 0, 8'd0));
        tv.push_back(mk(0, 1, 1, 8'h01, 3'd1, 0, 8'd0));
        tv.push_back(mk(0, 0, 1, 8'h02, 3'd2, 0, 8'd0));
        tv.push_back(mk(0, 1, 1, 8'h05, 3'd3, 0, 8'd0));
        tv.push_back(mk(1, 1, 1, 8'h00, 3'd0, 0, 8'd0));
        tv.push_back(mk(0, 1, 1, 8'h01, 3'd1, 0, 8'd0));
        tv.push_back(mk(0, 0, 0, 8'h01, 3'd1, 0, 8'd0));
        foreach (tv[i]) begin
            step(tv[i].rst, tv[i].d, tv[i].v);
            check($sformatf("v%0d shift_q", i), 32'(shift_q), 32'(tv[i].sh));
            check($sformatf("v%0d state", i), 32'(state), 32'(tv[i].st));
            check($sformatf("v%0d detect", i), 32'(detect), 32'(tv[i].det));
            check($sformatf("v%0d match_count", i), 32'(match_count), 32'(tv[i].cnt));
        end
        // saturation on the CNT_W=2 instance: 1011 five times
        step(1, 0, 0);
        check("sat reset count", 32'(count2), 32'd0);
        for (int k = 0; k < 5; k++) begin
            for (int b = 0; b < 4; b++) begin
                step(0, b != 1, 1);
                check($sformatf("sat k%0d b%0d detect", k, b), 32'(detect2), 32'(b == 3));
                check($sformatf("sat k%0d b%0d count", k, b), 32'(count2),
                      32'((b == 3) ? ((k + 1 > 3) ? 3 : k + 1) : ((k > 3) ? 3 : k)));
            end
        end
        step(0, 0, 0);
        check("sat idle detect", 32'(detect2), 32'd0);
        check("sat idle count", 32'(count2), 32'd3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
